sap_ctrl_seq: RTL and testbench

//  SAP-1 controller-sequencer: the initiator side of the W-bus control interface that the

---
 rtl/sap_ctrl_seq_pkg.sv | 28 ++
 rtl/sap_ctrl_seq_if.sv | 43 ++++
 rtl/sap_ctrl_seq_ring_counter.sv | 45 ++++
 rtl/sap_ctrl_seq.sv | 128 ++++++++++++
 tb/tb_sap_ctrl_seq.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sap_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_ctrl_seq_pkg
//  Brief    : Shared constants for the SAP-1 controller-sequencer: opcode
//             encodings, T-state indices and bus widths.
//  Revision : 1.0  initial release
// ============================================================================
package sap_ctrl_seq_pkg;

  localparam int OPW   = 4;
  localparam int NUM_T = 6;

  localparam logic [OPW-1:0] OP_LDA = 4'b0000;
  localparam logic [OPW-1:0] OP_ADD = 4'b0001;
  localparam logic [OPW-1:0] OP_SUB = 4'b0010;
  localparam logic [OPW-1:0] OP_OUT = 4'b1110;
  localparam logic [OPW-1:0] OP_HLT = 4'b1111;

  // Bit positions of each T-state in the one-hot ring (bit0 = T1)
  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

endpackage
`default_nettype wire

// File: rtl/sap_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : sap_ctrl_seq_if
//  Brief    : Control interface between the sequencer (master) and the
//             register/ALU datapath (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface sap_ctrl_seq_if
  import sap_ctrl_seq_pkg::*;
#(
  parameter int OPW_P   = OPW,
  parameter int NUM_T_P = NUM_T
);
  logic               step;
  logic [OPW_P-1:0]   opcode;
  logic [NUM_T_P-1:0] t_state;
  logic               halted;
  logic               pc_inc;
  logic               pc_en;
  logic               mar_latch;
  logic               ram_en;
  logic               ir_latch;
  logic               ir_en;
  logic               a_latch;
  logic               a_enable;
  logic               b_latch;
  logic               alu_enable;
  logic               alu_sub;
  logic               out_latch;

  modport master (
    input  step, opcode,
    output t_state, halted, pc_inc, pc_en, mar_latch, ram_en, ir_latch, ir_en,
           a_latch, a_enable, b_latch, alu_enable, alu_sub, out_latch
  );

  modport slave (
    output step, opcode,
    input  t_state, halted, pc_inc, pc_en, mar_latch, ram_en, ir_latch, ir_en,
           a_latch, a_enable, b_latch, alu_enable, alu_sub, out_latch
  );
endinterface
`default_nettype wire

// File: rtl/sap_ctrl_seq_ring_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sap_ctrl_seq_ring_counter
//  Brief    : One-hot T-state ring. Rotates on adv_i, jumps to T1 on
//             load_t1_i (load wins), async active-low reset to T1.
//  Revision : 1.0  initial release
// ============================================================================
module sap_ctrl_seq_ring_counter #(
  parameter int NUM_T = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             adv_i,
  input  wire logic             load_t1_i,
  output logic      [NUM_T-1:0] t_state_o
);

  localparam logic [NUM_T-1:0] T1_ONEHOT = {{(NUM_T-1){1'b0}}, 1'b1};

  logic [NUM_T-1:0] ring_q;
  logic [NUM_T-1:0] ring_d;

  // Next ring value: short-cycle back to T1, else rotate left by one
  always_comb begin
    ring_d = ring_q;
    if (load_t1_i) begin
      ring_d = T1_ONEHOT;
    end else if (adv_i) begin
      ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
    end
  end

  // Ring register with asynchronous return to T1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q <= T1_ONEHOT;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign t_state_o = ring_q;

endmodule
`default_nettype wire

// File: rtl/sap_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sap_ctrl_seq
//  Brief    : SAP-1 controller-sequencer. Steps the T1..T6 ring on each step
//             pulse, decodes the IR opcode and drives the datapath strobes.
//             HLT in T4 freezes the sequencer until rst_n.
//  Config   : SAP_CTRL_SKIP_NOP_EN - when defined, an instruction whose
//             remaining T-states are all idle returns to T1 early.
//  Revision : 1.0  initial release
// ============================================================================
module sap_ctrl_seq
  import sap_ctrl_seq_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  sap_ctrl_seq_if.master  ctl
);

  logic [NUM_T-1:0] t_state_w;
  logic             halted_q;
  logic             halted_d;
  logic             is_lda, is_add, is_sub, is_out, is_hlt;
  logic             run_w;
  logic             halt_now_w;
  logic             adv_w;
  logic             skip_w;

  assign is_lda = (ctl.opcode == OP_LDA);
  assign is_add = (ctl.opcode == OP_ADD);
  assign is_sub = (ctl.opcode == OP_SUB);
  assign is_out = (ctl.opcode == OP_OUT);
  assign is_hlt = (ctl.opcode == OP_HLT);

  // A step while halted is ignored; HLT in T4 consumes the step to freeze
  assign run_w      = ctl.step & ~halted_q;
  assign halt_now_w = run_w & t_state_w[T4_IDX] & is_hlt;
  assign adv_w      = run_w & ~halt_now_w;

`ifdef SAP_CTRL_SKIP_NOP_EN
  // Tail of the instruction is idle: T4 of OUT/NOP, T5 of anything but ADD/SUB
  assign skip_w = adv_w & ((t_state_w[T4_IDX] & ~is_lda & ~is_add & ~is_sub & ~is_hlt) |
                           (t_state_w[T5_IDX] & ~is_add & ~is_sub));
`else
  assign skip_w = 1'b0;
`endif

  sap_ctrl_seq_ring_counter #(
    .NUM_T (NUM_T)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (adv_w),
    .load_t1_i (skip_w),
    .t_state_o (t_state_w)
  );

  // Halt flag is sticky; only rst_n clears it
  always_comb begin
    halted_d = halted_q | halt_now_w;
  end

  // Halt register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Control-word decode from T-state and opcode; all strobes idle when halted
  always_comb begin
    ctl.pc_inc     = 1'b0;
    ctl.pc_en      = 1'b0;
    ctl.mar_latch  = 1'b0;
    ctl.ram_en     = 1'b0;
    ctl.ir_latch   = 1'b0;
    ctl.ir_en      = 1'b0;
    ctl.a_latch    = 1'b0;
    ctl.a_enable   = 1'b0;
    ctl.b_latch    = 1'b0;
    ctl.alu_enable = 1'b0;
    ctl.alu_sub    = 1'b0;
    ctl.out_latch  = 1'b0;
    if (!halted_q) begin
      if (t_state_w[T1_IDX]) begin
        ctl.pc_en     = 1'b1;
        ctl.mar_latch = 1'b1;
      end
      if (t_state_w[T2_IDX]) begin
        ctl.pc_inc = 1'b1;
      end
      if (t_state_w[T3_IDX]) begin
        ctl.ram_en   = 1'b1;
        ctl.ir_latch = 1'b1;
      end
      if (t_state_w[T4_IDX]) begin
        if (is_lda | is_add | is_sub) begin
          ctl.ir_en     = 1'b1;
          ctl.mar_latch = 1'b1;
        end
        if (is_out) begin
          ctl.a_enable  = 1'b1;
          ctl.out_latch = 1'b1;
        end
      end
      if (t_state_w[T5_IDX]) begin
        if (is_lda | is_add | is_sub) begin
          ctl.ram_en = 1'b1;
        end
        ctl.a_latch = is_lda;
        ctl.b_latch = is_add | is_sub;
      end
      if (t_state_w[T6_IDX]) begin
        if (is_add | is_sub) begin
          ctl.alu_enable = 1'b1;
          ctl.a_latch    = 1'b1;
        end
        ctl.alu_sub = is_sub;
      end
    end
  end

  assign ctl.t_state = t_state_w;
  assign ctl.halted  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sap_ctrl_seq
//  Brief    : Scoreboard bench for sap_ctrl_seq with a T-state/control-word
//             reference model built from the instruction table.
//  Config   : honours SAP_CTRL_SKIP_NOP_EN in the reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sap_ctrl_seq;

  // Control-word bit masks, order {pc_inc .. out_latch}
  localparam logic [11:0] S_PCI = 12'h800, S_PCE = 12'h400, S_MAR = 12'h200,
                          S_RAM = 12'h100, S_IRL = 12'h080, S_IRE = 12'h040,
                          S_AL  = 12'h020, S_AE  = 12'h010, S_BL  = 12'h008,
                          S_ALU = 12'h004, S_SUB = 12'h002, S_OUT = 12'h001;

  typedef struct packed {
    logic [5:0]  t;
    logic        h;
    logic [11:0] s;
  } exp_t;

  logic clk;
  logic rst_n;
  sap_ctrl_seq_if bus ();

  sap_ctrl_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  int   m_t;
  bit   m_halt;
  bit   skip_en;

  // Control word the instruction table calls for at T-state t (1..6)
  function automatic logic [11:0] table_word(input logic [3:0] op, input int t, input bit h);
    logic [11:0] w;
    w = 12'h000;
    if (!h) begin
      case (t)
        1: w = S_PCE | S_MAR;
        2: w = S_PCI;
        3: w = S_RAM | S_IRL;
        4: if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) w = S_IRE | S_MAR;
           else if (op == 4'b1110) w = S_AE | S_OUT;
        5: if (op == 4'b0000) w = S_RAM | S_AL;
           else if (op == 4'b0001 || op == 4'b0010) w = S_RAM | S_BL;
        6: if (op == 4'b0001) w = S_ALU | S_AL;
           else if (op == 4'b0010) w = S_ALU | S_AL | S_SUB;
        default: w = 12'h000;
      endcase
    end
    return w;
  endfunction

  // True when every T-state after t does nothing for this opcode
  function automatic bit tail_idle(input logic [3:0] op, input int t);
    for (int k = t + 1; k <= 6; k++) begin
      if (table_word(op, k, 1'b0) != 12'h000) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [11:0] dut_word();
    return {bus.pc_inc, bus.pc_en, bus.mar_latch, bus.ram_en, bus.ir_latch, bus.ir_en,
            bus.a_latch, bus.a_enable, bus.b_latch, bus.alu_enable, bus.alu_sub, bus.out_latch};
  endfunction

  // One clock: drive inputs, queue expected outputs, advance model at the edge
  task automatic cycle(input bit st, input logic [3:0] op);
    exp_t e;
    @(negedge clk);
    bus.step   = st;
    bus.opcode = op;
    #1;
    e.t = 6'(1 << (m_t - 1));
    e.h = m_halt;
    e.s = table_word(op, m_t, m_halt);
    sb_q.push_back(e);
    @(posedge clk);
    if (!m_halt && st) begin
      if (m_t == 4 && op == 4'b1111) m_halt = 1'b1;
      else if (m_t == 6 || (skip_en && m_t >= 4 && tail_idle(op, m_t))) m_t = 1;
      else m_t = m_t + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.step = 1'b0;
    rst_n    = 1'b0;
    #3;
    rst_n  = 1'b1;
    m_t    = 1;
    m_halt = 1'b0;
  endtask

  // Steps needed from T1 back to T1 for one instruction
  task automatic measure_len(input logic [3:0] op, input int want, input string name);
    int n;
    n = 0;
    do begin
      cycle(1'b1, op);
      n++;
      #1;
    end while (bus.t_state != 6'b000001 && n < 10);
    total++;
    if (n != want) begin
      bad++;
      $display("FAIL len_%s: got %0d steps want %0d", name, n, want);
    end
  endtask

  // Monitor: compare every queued expectation and the bus-driver rule each cycle
  always @(negedge clk) begin
    exp_t e;
    logic [11:0] w;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      w = dut_word();
      total++;
      if (bus.t_state !== e.t || bus.halted !== e.h || w !== e.s) begin
        bad++;
        $display("FAIL sb: got t=%b h=%b s=%h want t=%b h=%b s=%h",
                 bus.t_state, bus.halted, w, e.t, e.h, e.s);
      end
    end
    total++;
    if ($countones({bus.pc_en, bus.ram_en, bus.ir_en, bus.a_enable, bus.alu_enable}) > 1) begin
      bad++;
      $display("FAIL bus_onehot: got enables %b want at most one",
               {bus.pc_en, bus.ram_en, bus.ir_en, bus.a_enable, bus.alu_enable});
    end
  end

  initial begin
    logic [3:0] rop;
`ifdef SAP_CTRL_SKIP_NOP_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    bus.step   = 1'b0;
    bus.opcode = 4'b0000;
    rst_n      = 1'b0;
    m_t        = 1;
    m_halt     = 1'b0;
    #12;
    rst_n = 1'b1;

    // Reset state, then hold with step low
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'b0000);
    // LDA full instruction
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0000);
    // SUB to T6 then flip opcode to ADD while sitting in T6
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0010);
    cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b0001);
    cycle(1'b1, 4'b0001);
    cycle(1'b0, 4'b0001);

    // HLT freezes, steps ignored, reset clears
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b1111);
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1111);
    do_reset();
    cycle(1'b0, 4'b1111);

    // Asynchronous reset at T5 of ADD
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0001);
    cycle(1'b0, 4'b0001);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.t_state !== 6'b000001 || bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got t=%b h=%b want t=000001 h=0", bus.t_state, bus.halted);
    end
    m_t    = 1;
    m_halt = 1'b0;
    #4;
    rst_n = 1'b1;
    cycle(1'b0, 4'b0001);

    // Instruction lengths
    measure_len(4'b0000, skip_en ? 5 : 6, "lda");
    measure_len(4'b1110, skip_en ? 4 : 6, "out");
    measure_len(4'b0101, skip_en ? 4 : 6, "nop");
    measure_len(4'b0001, 6, "add");
    measure_len(4'b0010, 6, "sub");

    // Randomized traffic; opcode mostly held per instruction
    rop = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 7) == 0) do_reset();
      if (m_t == 1 || $urandom_range(0, 15) == 0) rop = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), rop);
    end

    @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
